// File: rtl/poly_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : poly_job_arbiter
// Brief    : Two-requester round-robin job controller sequencing a shared
//            polynomial datapath to compute A*x^2 + B*x + C.
// Revision : 1.0 - initial release
// ============================================================================
module poly_job_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [1:0]     req_i,
    input  logic [4*W-1:0] job0_i,
    input  logic [4*W-1:0] job1_i,
    output logic [1:0]     ack_o,
    output logic [1:0]     done_o,
    output logic [W-1:0]   result_o,
    output logic           busy_o,
    output logic           ld_a,
    output logic           ld_b,
    output logic           ld_c,
    output logic           ld_x,
    output logic           ld_r,
    output logic           ld_alu_out,
    output logic [1:0]     alu_select_a,
    output logic [1:0]     alu_select_b,
    output logic           alu_op,
    output logic [W-1:0]   data_in,
    input  logic [W-1:0]   data_result
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LD_A = 4'd1,
        S_LD_B = 4'd2,
        S_LD_C = 4'd3,
        S_LD_X = 4'd4,
        S_CYC0 = 4'd5,
        S_CYC1 = 4'd6,
        S_CYC2 = 4'd7,
        S_CYC3 = 4'd8,
        S_CYC4 = 4'd9,
        S_RESP = 4'd10
    } state_t;

    localparam logic [1:0] c_SEL_A = 2'd0;
    localparam logic [1:0] c_SEL_B = 2'd1;
    localparam logic [1:0] c_SEL_C = 2'd2;
    localparam logic [1:0] c_SEL_X = 2'd3;
    localparam logic       c_OP_ADD = 1'b0;
    localparam logic       c_OP_MUL = 1'b1;

    state_t         r_state;
    logic           r_last_grant;
    logic           r_owner;
    logic [W-1:0]   r_hold_b;
    logic [W-1:0]   r_hold_c;
    logic [W-1:0]   r_hold_x;
    logic [W-1:0]   r_result;
    logic [1:0]     r_done;
    logic           r_busy;
    logic           r_ld_a, r_ld_b, r_ld_c, r_ld_x, r_ld_r, r_ld_alu_out;
    logic [1:0]     r_sel_a, r_sel_b;
    logic           r_op;
    logic [W-1:0]   r_data_in;

    logic           w_any_req;
    logic           w_grant_idx;
    logic [4*W-1:0] w_job;

    // A tie goes to whichever requester was not served last.
    assign w_any_req   = |req_i;
    assign w_grant_idx = (req_i == 2'b11) ? ~r_last_grant : req_i[1];
    assign w_job       = w_grant_idx ? job1_i : job0_i;

    assign ack_o = (r_state == S_IDLE && w_any_req) ?
                   (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;

    // The datapath result lands on the RESP edge, so bypass it during RESP
    // and hold the registered copy afterwards.
    assign result_o = (r_state == S_RESP) ? data_result : r_result;

    assign done_o       = r_done;
    assign busy_o       = r_busy;
    assign ld_a         = r_ld_a;
    assign ld_b         = r_ld_b;
    assign ld_c         = r_ld_c;
    assign ld_x         = r_ld_x;
    assign ld_r         = r_ld_r;
    assign ld_alu_out   = r_ld_alu_out;
    assign alu_select_a = r_sel_a;
    assign alu_select_b = r_sel_b;
    assign alu_op       = r_op;
    assign data_in      = r_data_in;

    // Controls are registered with the value belonging to the state entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_hold_b     <= '0;
            r_hold_c     <= '0;
            r_hold_x     <= '0;
            r_result     <= '0;
            r_done       <= 2'b00;
            r_busy       <= 1'b0;
            r_ld_a       <= 1'b0;
            r_ld_b       <= 1'b0;
            r_ld_c       <= 1'b0;
            r_ld_x       <= 1'b0;
            r_ld_r       <= 1'b0;
            r_ld_alu_out <= 1'b0;
            r_sel_a      <= c_SEL_A;
            r_sel_b      <= c_SEL_A;
            r_op         <= c_OP_ADD;
            r_data_in    <= '0;
        end else begin
            r_done       <= 2'b00;
            r_ld_a       <= 1'b0;
            r_ld_b       <= 1'b0;
            r_ld_c       <= 1'b0;
            r_ld_x       <= 1'b0;
            r_ld_r       <= 1'b0;
            r_ld_alu_out <= 1'b0;
            r_sel_a      <= c_SEL_A;
            r_sel_b      <= c_SEL_A;
            r_op         <= c_OP_ADD;
            r_data_in    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_LD_A;
                        r_owner      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_busy       <= 1'b1;
                        r_ld_a       <= 1'b1;
                        {r_data_in, r_hold_b, r_hold_c, r_hold_x} <= w_job;
                    end
                end
                S_LD_A: begin
                    r_state   <= S_LD_B;
                    r_ld_b    <= 1'b1;
                    r_data_in <= r_hold_b;
                end
                S_LD_B: begin
                    r_state   <= S_LD_C;
                    r_ld_c    <= 1'b1;
                    r_data_in <= r_hold_c;
                end
                S_LD_C: begin
                    r_state   <= S_LD_X;
                    r_ld_x    <= 1'b1;
                    r_data_in <= r_hold_x;
                end
                S_LD_X, S_CYC0: begin
                    r_state      <= (r_state == S_LD_X) ? S_CYC0 : S_CYC1;
                    r_ld_a       <= 1'b1;
                    r_ld_alu_out <= 1'b1;
                    r_sel_a      <= c_SEL_A;
                    r_sel_b      <= c_SEL_X;
                    r_op         <= c_OP_MUL;
                end
                S_CYC1: begin
                    r_state      <= S_CYC2;
                    r_ld_b       <= 1'b1;
                    r_ld_alu_out <= 1'b1;
                    r_sel_a      <= c_SEL_B;
                    r_sel_b      <= c_SEL_X;
                    r_op         <= c_OP_MUL;
                end
                S_CYC2: begin
                    r_state      <= S_CYC3;
                    r_ld_b       <= 1'b1;
                    r_ld_alu_out <= 1'b1;
                    r_sel_a      <= c_SEL_B;
                    r_sel_b      <= c_SEL_C;
                    r_op         <= c_OP_ADD;
                end
                S_CYC3: begin
                    r_state <= S_CYC4;
                    r_ld_r  <= 1'b1;
                    r_sel_a <= c_SEL_A;
                    r_sel_b <= c_SEL_B;
                    r_op    <= c_OP_ADD;
                end
                S_CYC4: begin
                    r_state <= S_RESP;
                    r_done  <= r_owner ? 2'b10 : 2'b01;
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_result <= data_result;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_job_arbiter
// Brief    : Directed self-checking bench for poly_job_arbiter with a
//            behavioural model of the shared polynomial datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_job_arbiter;

    logic        clk;
    logic        resetn;
    logic [1:0]  req_i;
    logic [31:0] job0_i, job1_i;
    logic [1:0]  ack_o, done_o;
    logic [7:0]  result_o;
    logic        busy_o;
    logic        ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out;
    logic [1:0]  alu_select_a, alu_select_b;
    logic        alu_op;
    logic [7:0]  data_in, data_result;

    int checks = 0;
    int errors = 0;

    poly_job_arbiter #(.W(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_i        (req_i),
        .job0_i       (job0_i),
        .job1_i       (job1_i),
        .ack_o        (ack_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .busy_o       (busy_o),
        .ld_a         (ld_a),
        .ld_b         (ld_b),
        .ld_c         (ld_c),
        .ld_x         (ld_x),
        .ld_r         (ld_r),
        .ld_alu_out   (ld_alu_out),
        .alu_select_a (alu_select_a),
        .alu_select_b (alu_select_b),
        .alu_op       (alu_op),
        .data_in      (data_in),
        .data_result  (data_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: registers a/b/c/x/r and an 8-bit add/multiply ALU.
    logic [7:0] dp_a, dp_b, dp_c, dp_x, dp_r, opa, opb, alu;
    always_comb begin
        opa = 8'd0;
        opb = 8'd0;
        case (alu_select_a)
            2'd0: opa = dp_a;
            2'd1: opa = dp_b;
            2'd2: opa = dp_c;
            default: opa = dp_x;
        endcase
        case (alu_select_b)
            2'd0: opb = dp_a;
            2'd1: opb = dp_b;
            2'd2: opb = dp_c;
            default: opb = dp_x;
        endcase
        alu = alu_op ? (opa * opb) : (opa + opb);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dp_a <= 8'd0; dp_b <= 8'd0; dp_c <= 8'd0; dp_x <= 8'd0; dp_r <= 8'd0;
        end else begin
            if (ld_a) dp_a <= ld_alu_out ? alu : data_in;
            if (ld_b) dp_b <= ld_alu_out ? alu : data_in;
            if (ld_c) dp_c <= ld_alu_out ? alu : data_in;
            if (ld_x) dp_x <= ld_alu_out ? alu : data_in;
            if (ld_r) dp_r <= alu;
        end
    end
    assign data_result = dp_r;

    logic [12:0] ctrl;
    assign ctrl = {ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out,
                   alu_select_a, alu_select_b, alu_op};

    // {ld_a,ld_b,ld_c,ld_x,ld_r,ld_alu_out,sel_a,sel_b,op} for cycle T+k.
    function automatic logic [12:0] exp_ctrl(input int k);
        case (k)
            1:       return 13'b1_0_0_0_0_0_00_00_0;
            2:       return 13'b0_1_0_0_0_0_00_00_0;
            3:       return 13'b0_0_1_0_0_0_00_00_0;
            4:       return 13'b0_0_0_1_0_0_00_00_0;
            5, 6:    return 13'b1_0_0_0_0_1_00_11_1;
            7:       return 13'b0_1_0_0_0_1_01_11_1;
            8:       return 13'b0_1_0_0_0_1_01_10_0;
            9:       return 13'b0_0_0_0_1_0_00_01_0;
            default: return 13'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Entered in the IDLE cycle T with requests already driven; returns in T+10.
    task automatic do_job(input logic [1:0] exp_ack, input logic [7:0] av, bv, cv, xv,
                          input logic [7:0] res, input logic [1:0] req_k1,
                          input logic [1:0] req_k5);
        logic [7:0] din;
        #1;
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("ack", {30'd0, ack_o}, {30'd0, exp_ack});
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) req_i = req_k1;
            if (k == 5) req_i = req_k5;
            #1;
            case (k)
                1: din = av;
                2: din = bv;
                3: din = cv;
                4: din = xv;
                default: din = 8'd0;
            endcase
            chk($sformatf("busy_k%0d", k), {31'd0, busy_o}, 32'd1);
            chk($sformatf("ack_quiet_k%0d", k), {30'd0, ack_o}, 32'd0);
            chk($sformatf("ctrl_k%0d", k), {19'd0, ctrl}, {19'd0, exp_ctrl(k)});
            chk($sformatf("data_in_k%0d", k), {24'd0, data_in}, {24'd0, din});
            chk($sformatf("done_k%0d", k), {30'd0, done_o},
                (k == 10) ? {30'd0, exp_ack} : 32'd0);
            if (k == 10) chk("result", {24'd0, result_o}, {24'd0, res});
        end
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] held);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_ack"}, {30'd0, ack_o}, 32'd0);
        chk({tag, "_done"}, {30'd0, done_o}, 32'd0);
        chk({tag, "_result"}, {24'd0, result_o}, {24'd0, held});
    endtask

    task automatic chk_all_zero(input string tag);
        chk_idle(tag, 8'd0);
        chk({tag, "_ctrl"}, {19'd0, ctrl}, 32'd0);
        chk({tag, "_din"}, {24'd0, data_in}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        req_i  = 2'b00;
        job0_i = 32'd0;
        job1_i = 32'd0;
        repeat (2) tick();
        #1;
        chk_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Single job on requester 0: 1*16 + 2*4 + 3 = 27
        job0_i = {8'd1, 8'd2, 8'd3, 8'd4};
        req_i  = 2'b01;
        do_job(2'b01, 8'd1, 8'd2, 8'd3, 8'd4, 8'h1B, 2'b00, 2'b00);
        tick(); #1;
        chk_idle("after_job1", 8'h1B);

        // Wrap-around on requester 1: 357 mod 256 = 0x65
        job1_i = {8'd3, 8'd5, 8'd7, 8'd10};
        req_i  = 2'b10;
        do_job(2'b10, 8'd3, 8'd5, 8'd7, 8'd10, 8'h65, 2'b00, 2'b00);
        tick(); #1;
        chk_idle("after_job2", 8'h65);

        // Tie after reset: requester 0 first, requester 1 at T+11
        resetn = 1'b0;
        #1;
        chk_all_zero("reset2");
        tick();
        resetn = 1'b1;
        tick();
        job0_i = {8'd1, 8'd1, 8'd1, 8'd2};
        job1_i = {8'd0, 8'd0, 8'd9, 8'd5};
        req_i  = 2'b11;
        do_job(2'b01, 8'd1, 8'd1, 8'd1, 8'd2, 8'd7, 2'b10, 2'b10);
        req_i = 2'b11;
        tick();
        do_job(2'b10, 8'd0, 8'd0, 8'd9, 8'd5, 8'd9, 2'b11, 2'b11);

        // Continuous contention: grants alternate, one ack per 11 cycles
        tick();
        do_job(2'b01, 8'd1, 8'd1, 8'd1, 8'd2, 8'd7, 2'b11, 2'b11);
        tick();
        do_job(2'b10, 8'd0, 8'd0, 8'd9, 8'd5, 8'd9, 2'b11, 2'b11);
        tick();
        do_job(2'b01, 8'd1, 8'd1, 8'd1, 8'd2, 8'd7, 2'b11, 2'b11);
        tick();
        do_job(2'b10, 8'd0, 8'd0, 8'd9, 8'd5, 8'd9, 2'b00, 2'b00);
        tick(); #1;
        chk_idle("after_contention", 8'd9);

        // Reset during CYC2 drops the job
        job1_i = {8'd3, 8'd5, 8'd7, 8'd10};
        req_i  = 2'b10;
        #1;
        chk("midrst_ack", {30'd0, ack_o}, 32'd2);
        tick();
        req_i = 2'b00;
        repeat (6) tick();
        #1;
        chk("midrst_in_cyc2", {19'd0, ctrl}, {19'd0, exp_ctrl(7)});
        resetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick(); #1;
        chk_all_zero("midrst_hold");
        resetn = 1'b1;
        repeat (3) begin
            tick(); #1;
            chk_idle("midrst_after", 8'd0);
        end
        job0_i = {8'd2, 8'd0, 8'd1, 8'd3};
        req_i  = 2'b01;
        do_job(2'b01, 8'd2, 8'd0, 8'd1, 8'd3, 8'd19, 2'b00, 2'b00);

        // Requests raised only while busy are ignored and leave no job behind
        tick();
        job1_i = {8'd3, 8'd5, 8'd7, 8'd10};
        req_i  = 2'b10;
        do_job(2'b10, 8'd3, 8'd5, 8'd7, 8'd10, 8'h65, 2'b11, 2'b00);
        repeat (3) begin
            tick(); #1;
            chk_idle("withdrawn", 8'h65);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
